// File: rtl/checkpoint_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: picks the oldest mispredict report,
// recalls its checkpoint, squashes the backend for a fixed window, then
// issues one front-end redirect. An older report arriving mid-recovery
// restarts the sequence on that branch.

// Per-lane age of a checkpoint id relative to the current base (natural wrap).
module crc_lane_age #(
  parameter int IDW = 3
) (
  input  logic [IDW-1:0] id,
  input  logic [IDW-1:0] base,
  output logic [IDW-1:0] age
);
  assign age = id - base;
endmodule

module checkpoint_recovery_ctrl #(
  parameter int NUM_CHECKPOINTS       = 8,
  parameter int NUM_BRANCHES_RESOLVED = 2,
  parameter int SQUASH_CYCLES         = 2,
  localparam int IDW = (NUM_CHECKPOINTS > 1) ? $clog2(NUM_CHECKPOINTS) : 1,
  localparam int NB  = NUM_BRANCHES_RESOLVED
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_stall,
  input  logic [IDW-1:0]         ckpt_back,
  input  logic [NB-1:0]          mispredict,
  input  logic [NB-1:0][IDW-1:0] mispredict_id,
  input  logic [NB-1:0][31:0]    mispredict_target,
  output logic                   recall_checkpoint,
  output logic [IDW-1:0]         recall_id,
  output logic                   squash,
  output logic                   frontend_stall,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   busy
);
  localparam int CW = $clog2(SQUASH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECALL, SQUASH, REDIRECT} state_t;

  state_t                   state, st_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [IDW-1:0]           act_id, base_q, base, act_age;
  logic [31:0]              act_pc;
  logic [NB-1:0][IDW-1:0]   lane_age;
  logic                     win_vld, preempt, latch;
  logic [IDW-1:0]           win_age, win_id;
  logic [31:0]              win_pc;

  // Ages are measured from the live checkpointer tail only while idle; during
  // recovery the tail may move, so the value captured at entry is used.
  assign base = (state == IDLE) ? ckpt_back : base_q;

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_lane
      crc_lane_age #(.IDW(IDW)) u_age (
        .id   (mispredict_id[g]),
        .base (base),
        .age  (lane_age[g])
      );
    end
  endgenerate

  // Oldest-wins arbitration; strict compare keeps ties on the lowest lane.
  always_comb begin
    win_vld = 1'b0;
    win_age = '0;
    win_id  = '0;
    win_pc  = '0;
    for (int i = 0; i < NB; i++) begin
      if (mispredict[i] && (!win_vld || lane_age[i] < win_age)) begin
        win_vld = 1'b1;
        win_age = lane_age[i];
        win_id  = mispredict_id[i];
        win_pc  = mispredict_target[i];
      end
    end
  end

  // Only a strictly older branch can preempt; same-or-younger reports belong
  // to instructions the current recovery is already squashing.
  assign act_age = act_id - base_q;
  assign preempt = (state != IDLE) && win_vld && (win_age < act_age);

  // Next-state: preemption / new mispredict override every other transition.
  always_comb begin
    st_nxt  = state;
    cnt_nxt = cnt;
    latch   = 1'b0;
    if (preempt || (state == IDLE && win_vld)) begin
      st_nxt  = RECALL;
      cnt_nxt = CW'(SQUASH_CYCLES);
      latch   = 1'b1;
    end else begin
      case (state)
        RECALL: begin
          st_nxt  = SQUASH;
          cnt_nxt = CW'(SQUASH_CYCLES);
        end
        SQUASH: begin
          if (cnt == CW'(1)) st_nxt = REDIRECT;
          else               cnt_nxt = cnt - CW'(1);
        end
        REDIRECT: if (!ext_stall) st_nxt = IDLE;
        default: ;
      endcase
    end
  end

  // State, recovery context and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      act_id            <= '0;
      act_pc            <= '0;
      base_q            <= '0;
      recall_checkpoint <= 1'b0;
      squash            <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= st_nxt;
      cnt               <= cnt_nxt;
      recall_checkpoint <= (st_nxt == RECALL);
      squash            <= (st_nxt == RECALL) || (st_nxt == SQUASH);
      busy              <= (st_nxt != IDLE);
      if (latch) begin
        act_id <= win_id;
        act_pc <= win_pc;
        if (state == IDLE) base_q <= ckpt_back;
      end
    end
  end

  assign recall_id      = act_id;
  assign frontend_stall = busy;
  assign redirect_pc    = act_pc;
  assign redirect_valid = (state == REDIRECT) && !ext_stall && !preempt;

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Directed, table-driven bench for checkpoint_recovery_ctrl plus a
// hand-written asynchronous-reset sequence.
module tb_checkpoint_recovery_ctrl;
  localparam int NC  = 8;
  localparam int NB  = 2;
  localparam int IDW = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ext_stall;
  logic [IDW-1:0]         ckpt_back;
  logic [NB-1:0]          mispredict;
  logic [NB-1:0][IDW-1:0] mispredict_id;
  logic [NB-1:0][31:0]    mispredict_target;
  logic                   recall_checkpoint;
  logic [IDW-1:0]         recall_id;
  logic                   squash;
  logic                   frontend_stall;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  checkpoint_recovery_ctrl #(
    .NUM_CHECKPOINTS(NC), .NUM_BRANCHES_RESOLVED(NB), .SQUASH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .ckpt_back(ckpt_back),
    .mispredict(mispredict), .mispredict_id(mispredict_id),
    .mispredict_target(mispredict_target),
    .recall_checkpoint(recall_checkpoint), .recall_id(recall_id),
    .squash(squash), .frontend_stall(frontend_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mp;
    logic [2:0]  id0;
    logic [31:0] t0;
    logic [2:0]  id1;
    logic [31:0] t1;
    logic [2:0]  cb;
    logic        st;
    logic        rc;
    logic [2:0]  rid;
    logic        sq;
    logic        bz;
    logic        rv;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [1:0] mp, logic [2:0] id0, logic [31:0] t0,
                             logic [2:0] id1, logic [31:0] t1, logic [2:0] cb,
                             logic st, logic rc, logic [2:0] rid, logic sq,
                             logic bz, logic rv, logic [31:0] pc);
    vec_t r;
    r.mp = mp; r.id0 = id0; r.t0 = t0; r.id1 = id1; r.t1 = t1; r.cb = cb;
    r.st = st; r.rc = rc; r.rid = rid; r.sq = sq; r.bz = bz; r.rv = rv;
    r.pc = pc;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    mispredict           = x.mp;
    mispredict_id[0]     = x.id0;
    mispredict_id[1]     = x.id1;
    mispredict_target[0] = x.t0;
    mispredict_target[1] = x.t1;
    ckpt_back            = x.cb;
    ext_stall            = x.st;
  endtask

  task automatic check_vec(vec_t x, string tag);
    chk({tag, " recall"}, 32'(recall_checkpoint), 32'(x.rc));
    chk({tag, " squash"}, 32'(squash), 32'(x.sq));
    chk({tag, " busy"}, 32'(busy), 32'(x.bz));
    chk({tag, " fe_stall"}, 32'(frontend_stall), 32'(x.bz));
    chk({tag, " redir_v"}, 32'(redirect_valid), 32'(x.rv));
    if (x.rc) chk({tag, " recall_id"}, 32'(recall_id), 32'(x.rid));
    if (x.rv) chk({tag, " redir_pc"}, redirect_pc, x.pc);
  endtask

  // Inputs change just after the edge; outputs are sampled mid-cycle.
  task automatic run_vec(vec_t x, string tag);
    @(posedge clk);
    #1 drive(x);
    @(negedge clk);
    check_vec(x, tag);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " recall"}, 32'(recall_checkpoint), 32'd0);
    chk({tag, " squash"}, 32'(squash), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " fe_stall"}, 32'(frontend_stall), 32'd0);
    chk({tag, " redir_v"}, 32'(redirect_valid), 32'd0);
    chk({tag, " recall_id"}, 32'(recall_id), 32'd0);
    chk({tag, " redir_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    vec_t idl;
    idl = v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic latency, ckpt_back=1, id 3
    tbl.push_back(v(2'b01, 3, 32'h1000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 1, 0, 1, 3, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h1000));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Wrap arbitration: base 6, id5 age7 vs id2 age4
    tbl.push_back(v(2'b11, 5, 32'h5000, 2, 32'h2000, 6, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 6, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 6, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 6, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 1, 32'h2000));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
    // Preempt in 2nd squash cycle; ckpt_back moves to 3 to prove base_q is used
    tbl.push_back(v(2'b01, 4, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b11, 6, 32'h6000, 1, 32'h1100, 3, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1100));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Tie on identical ids -> lane 0
    tbl.push_back(v(2'b11, 2, 32'h200, 2, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ext_stall holds the redirect for 3 cycles
    tbl.push_back(v(2'b01, 5, 32'h5500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5500));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Preempt during REDIRECT suppresses the redirect; younger report ignored
    tbl.push_back(v(2'b01, 7, 32'h7000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 7, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b01, 3, 32'h3300, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0));
    tbl.push_back(v(2'b01, 5, 32'h5050, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3300));
    tbl.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    reset = 1'b0;
    drive(idl);
    #1 chk_all_zero("reset");
    #6 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of SQUASH
    for (int i = 0; i < 3; i++) run_vec(tbl[i], $sformatf("ar_pre%0d", i));
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #1 chk_all_zero("rst_hold");
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) run_vec(idl, $sformatf("post_idle%0d", i));
    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("post_rst%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/checkpoint_recovery_ctrl.md
Name: checkpoint_recovery_ctrl

Overview:
- Sequences branch-mispredict recovery around the checkpoint store.
- Arbitrates among up to NUM_BRANCHES_RESOLVED mispredict reports per cycle and selects the oldest.
- Drives the checkpointer recall, squashes the backend for a fixed window, then issues a single front-end redirect.
- Sits between the branch resolution units and the checkpointer / rename / fetch blocks.

Parameters:
- NUM_CHECKPOINTS, `NUM_CHECKPOINTS (8): checkpoint slots; power of two.
- NUM_BRANCHES_RESOLVED, `NUM_BRANCHES_RESOLVED (2): mispredict report lanes per cycle.
- SQUASH_CYCLES, 2: cycles of squash after the recall cycle; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ext_stall  in  1  downstream stall; holds the redirect.
- ckpt_back  in  $clog2(NUM_CHECKPOINTS)  oldest live checkpoint id, from the checkpointer.
- mispredict  in  1 [NUM_BRANCHES_RESOLVED]  per-lane mispredict report.
- mispredict_id  in  $clog2(NUM_CHECKPOINTS) [NUM_BRANCHES_RESOLVED]  checkpoint id of the mispredicted branch.
- mispredict_target  in  32 [NUM_BRANCHES_RESOLVED]  correct PC.
- recall_checkpoint  out  1  recall strobe to the checkpointer.
- recall_id  out  $clog2(NUM_CHECKPOINTS)  checkpoint to restore.
- squash  out  1  kill in-flight backend instructions.
- frontend_stall  out  1  hold fetch/rename.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  32  redirect target.
- busy  out  1  recovery in progress (state != IDLE).

Behaviour:
Age and arbitration:
- age(id) = (id - base) mod NUM_CHECKPOINTS, computed in $clog2(NUM_CHECKPOINTS) bits with natural wrap.
- base = ckpt_back in IDLE; otherwise base_q, latched from ckpt_back on the IDLE->RECALL transition.
- Winner = valid lane with minimum age. Ties, including identical ids, go to the lowest lane index.
- Winner id and target are latched into act_id / act_pc.

States: IDLE, RECALL, SQUASH, REDIRECT.
- IDLE: any mispredict -> RECALL, latching the winner and base_q.
- RECALL (exactly one cycle):
  - recall_checkpoint=1, recall_id=act_id, squash=1.
  - Next state SQUASH; squash counter loads SQUASH_CYCLES.
- SQUASH:
  - squash=1; counter decrements each cycle.
  - At count 1 -> REDIRECT.
- REDIRECT:
  - redirect_valid = !ext_stall && !preempt, with redirect_pc=act_pc.
  - Stays in REDIRECT while ext_stall=1. On fire -> IDLE.
- frontend_stall = busy = 1 in RECALL, SQUASH and REDIRECT.

Preemption:
- In any non-IDLE state, a valid report with age < age(act_id) relative to base_q is a preempt.
- On preempt: next state RECALL with the new winner; the counter restarts; redirect is suppressed in that cycle.
- Reports with age >= age(act_id) are ignored; they are squashed younger branches.
- Preemption takes priority over every other transition.

Outputs and timing:
- recall_checkpoint, recall_id, squash, busy and frontend_stall are driven from registered state.
- redirect_valid is combinational from state, ext_stall and preempt.
- redirect_pc = act_pc whenever valid; it is don't-care otherwise, but is driven by act_pc.
- Latency: mispredict in cycle T -> recall T+1 -> squash T+1..T+1+SQUASH_CYCLES -> redirect T+2+SQUASH_CYCLES (no ext_stall) -> IDLE T+3+SQUASH_CYCLES.
- ext_stall does not delay RECALL or SQUASH.

Reset:
- Asynchronous on reset=0 in any state: state=IDLE; act_id, act_pc, base_q and counter = 0.
- All outputs 0 immediately.
- The first mispredict is sampled on the first clk edge after release.

Test Plan:
1. SQUASH_CYCLES=2, ckpt_back=1; lane0 mispredict id=3, target=0x1000 at T -> recall_checkpoint=1 with recall_id=3 at T+1; squash=1 at T+1..T+3; redirect_valid=1 with redirect_pc=0x1000 at T+4; busy=0 at T+5.
2. Wrap arbitration: ckpt_back=6; lane0 id=5 (age 7), lane1 id=2 (age 4), same cycle -> recall_id=2 and redirect_pc = lane1 target.
3. Preempt: ckpt_back=0, active id=4; in the 2nd SQUASH cycle lane0 id=6 and lane1 id=1 arrive -> RECALL next cycle with recall_id=1, counter restarted; id=6 ignored; redirect 3 cycles later with id=1's target.
4. Tie: both lanes id=2, targets 0x200 / 0x300 -> redirect_pc=0x200.
5. ext_stall=1 for 3 cycles on REDIRECT entry -> redirect_valid=0 and busy=1 throughout; redirect_valid=1 in the first cycle with ext_stall=0; IDLE the cycle after.
6. reset=0 mid-SQUASH (asynchronous, between edges) -> squash, busy and frontend_stall drop without waiting for clk. After release with no mispredicts, all outputs stay 0; a new mispredict then follows the timing of scenario 1.
